div_unit: RTL and testbench

Iterative RV32M divide/remainder unit for the pipelined RISC-V CPU, sitting in EX beside the single-cycle ALU. The ALU finishes every operation combinationally in one cycle. This block is the multi-cycle counterpart: it accepts a request, holds the pipeline via `Busy`, and returns one registered result with a `Done` pulse. Operations are DIV, DIVU, REM and REMU, using radix-2 restoring division on operand magnitudes with a final sign-correction step.

---
 rtl/div_unit.sv | 184 ++++++++++++++++++
 tb/tb_div_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU, radix-2 restoring division on magnitudes
// followed by a one-cycle sign-fix step. Define DIV_BYPASS_EN to answer divide-by-zero and
// signed-overflow requests in the accepting cycle instead of running the full iteration.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start,
    input  logic [1:0]  DivOp,
    input  logic [31:0] Operand1,
    input  logic [31:0] Operand2,
    input  logic        Flush,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Result,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] op1_q, op1_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        div0_q, div0_d;
    logic        ovf_q, ovf_d;

    logic        signed_op, a_neg, b_neg, in_div0, in_ovf, bypass_hit;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted;
    logic [33:0] trial;
    logic [31:0] fixed_q, fixed_r, fix_val;

    // Architectural results for divide-by-zero and signed overflow.
    function automatic logic [31:0] special_val(input logic [1:0] op, input logic [31:0] a,
                                                input logic div0);
        if (div0)
            return op[1] ? a : 32'hFFFF_FFFF;
        return op[1] ? 32'h0000_0000 : 32'h8000_0000;
    endfunction

    assign signed_op = ~DivOp[0];
    assign a_neg     = signed_op & Operand1[31];
    assign b_neg     = signed_op & Operand2[31];
    assign a_mag     = a_neg ? -Operand1 : Operand1;
    assign b_mag     = b_neg ? -Operand2 : Operand2;
    assign in_div0   = (Operand2 == 32'h0);
    assign in_ovf    = signed_op && (Operand1 == 32'h8000_0000) && (Operand2 == 32'hFFFF_FFFF);

`ifdef DIV_BYPASS_EN
    assign bypass_hit = in_div0 | in_ovf;
`else
    assign bypass_hit = 1'b0;
`endif

    // 34-bit trial subtract: the shifted remainder can reach 33 bits for large unsigned divisors.
    assign shifted = {rem_q, quo_q[31]};
    assign trial   = {1'b0, shifted} - {2'b00, dvsr_q};

    assign fixed_q = qneg_q ? -quo_q : quo_q;
    assign fixed_r = rneg_q ? -rem_q : rem_q;
    assign fix_val = (div0_q || ovf_q) ? special_val(op_q, op1_q, div0_q)
                                       : (op_q[1] ? fixed_r : fixed_q);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        op_d     = op_q;
        op1_d    = op1_q;
        dvsr_d   = dvsr_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        div0_d   = div0_q;
        ovf_d    = ovf_q;

        if (Flush) begin
            state_d = S_IDLE;
            cnt_d   = 5'd0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (Start) begin
                        op_d   = DivOp;
                        op1_d  = Operand1;
                        dvsr_d = b_mag;
                        quo_d  = a_mag;
                        rem_d  = 32'h0;
                        qneg_d = (DivOp == 2'b00) && (a_neg ^ b_neg);
                        rneg_d = (DivOp == 2'b10) && a_neg;
                        div0_d = in_div0;
                        ovf_d  = in_ovf;
                        if (bypass_hit) begin
                            result_d = special_val(DivOp, Operand1, in_div0);
                            done_d   = 1'b1;
                        end else begin
                            state_d = S_CALC;
                            cnt_d   = 5'd0;
                            busy_d  = 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (!trial[33]) begin
                        rem_d = trial[31:0];
                        quo_d = {quo_q[30:0], 1'b1};
                    end else begin
                        rem_d = shifted[31:0];
                        quo_d = {quo_q[30:0], 1'b0};
                    end
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31)
                        state_d = S_FIX;
                end
                S_FIX: begin
                    result_d = fix_val;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= 32'h0;
            op_q     <= 2'b00;
            op1_q    <= 32'h0;
            dvsr_q   <= 32'h0;
            rem_q    <= 32'h0;
            quo_q    <= 32'h0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            op_q     <= op_d;
            op1_q    <= op1_d;
            dvsr_q   <= dvsr_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            div0_q   <= div0_d;
            ovf_q    <= ovf_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed tests for div_unit against a transaction-level reference model
// that is compared with Busy/Done/Result on every falling clock edge.
module tb_div_unit;

    logic        clk;
    logic        rst_n;
    logic        Start;
    logic [1:0]  DivOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic        Flush;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Start     (Start),
        .DivOp     (DivOp),
        .Operand1  (Operand1),
        .Operand2  (Operand2),
        .Flush     (Flush),
        .Busy      (Busy),
        .Done      (Done),
        .Result    (Result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        if (b == 32'h0)
            return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                return op[1] ? 32'h0 : 32'h8000_0000;
            return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    bit          bypass_build;
`ifdef DIV_BYPASS_EN
    initial bypass_build = 1'b1;
`else
    initial bypass_build = 1'b0;
`endif

    int          m_left;
    bit          m_busy, m_done;
    logic [31:0] m_res, m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 32'h0;
        end else begin
            m_done = 1'b0;
            if (Flush) begin
                m_left = 0;
                m_busy = 1'b0;
            end else if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (Start) begin
                m_pend = ref_result(DivOp, Operand1, Operand2);
                if (bypass_build && is_special(DivOp, Operand1, Operand2)) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end else begin
                    m_left = 33;
                    m_busy = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("busy_vs_model", {31'h0, Busy}, {31'h0, m_busy});
        check("done_vs_model", {31'h0, Done}, {31'h0, m_done});
        check("result_vs_model", Result, m_res);
        check("done_busy_exclusive", {31'h0, Done & Busy}, 32'h0);
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the Done edge.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_edges,
                         input int poke_at);
        int k;
        int busy_cnt;
        Start    = 1'b1;
        DivOp    = op;
        Operand1 = a;
        Operand2 = b;
        @(posedge clk);
        #1;
        Start    = 1'b0;
        k        = 0;
        busy_cnt = 0;
        while (!Done && k < 100) begin
            if (Busy) busy_cnt++;
            if (poke_at > 0 && k == poke_at) begin
                Start    = 1'b1;
                DivOp    = 2'b01;
                Operand1 = 32'd7;
                Operand2 = 32'd7;
            end else begin
                Start = 1'b0;
            end
            @(posedge clk);
            #1;
            k++;
        end
        Start = 1'b0;
        check({name, "_result"}, Result, exp_res);
        check({name, "_done_edges"}, k, exp_edges);
        check({name, "_busy_cycles"}, busy_cnt, (exp_edges == 0) ? 0 : 33);
    endtask

    task automatic watch_no_done(input string name, input int n);
        int seen;
        seen = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (Done) seen++;
        end
        check(name, seen, 0);
    endtask

    // ---------------- directed sequence ----------------
    int spec_edges;

    initial begin
        rst_n    = 1'b0;
        Start    = 1'b0;
        DivOp    = 2'b00;
        Operand1 = 32'h0;
        Operand2 = 32'h0;
        Flush    = 1'b0;
        spec_edges = bypass_build ? 0 : 33;
        #1;
        check("reset_busy", {31'h0, Busy}, 32'h0);
        check("reset_done", {31'h0, Done}, 32'h0);
        check("reset_result", Result, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);

        // Model sanity against hand-computed values.
        check("model_divu", ref_result(2'b01, 32'd100, 32'd7), 32'd14);
        check("model_rem_neg", ref_result(2'b10, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("model_div_ovf", ref_result(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
        tick(2);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 33, 0);
        tick(2);
        do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        tick(1);
        do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
        tick(1);
        do_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        tick(1);
        do_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 33, 0);
        tick(1);
        do_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 33, 0);
        tick(1);
        do_op("rem_7_m2_again", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 33, 0);
        tick(1);

        // Flush ten cycles into DIVU 1000/3.
        Start    = 1'b1;
        DivOp    = 2'b01;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        tick(1);
        Start = 1'b0;
        tick(9);
        Flush = 1'b1;
        tick(1);
        Flush = 1'b0;
        check("flush_busy", {31'h0, Busy}, 32'h0);
        check("flush_done", {31'h0, Done}, 32'h0);
        check("flush_result_kept", Result, 32'd1);
        watch_no_done("flush_no_done", 40);

        // Flush together with Start drops the request.
        Start    = 1'b1;
        Flush    = 1'b1;
        tick(1);
        Start = 1'b0;
        Flush = 1'b0;
        check("flush_start_dropped", {31'h0, Busy}, 32'h0);
        tick(2);

        do_op("divu_1000_3_poked", 2'b01, 32'd1000, 32'd3, 32'd333, 33, 5);
        tick(2);

        do_op("div_by_zero", 2'b00, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, spec_edges, 0);
        tick(1);
        do_op("remu_by_zero", 2'b11, 32'h1234_5678, 32'h0, 32'h1234_5678, spec_edges, 0);
        tick(1);
        do_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, spec_edges, 0);
        tick(1);
        do_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, spec_edges, 0);
        tick(2);

        // Asynchronous reset fifteen cycles into an operation.
        Start    = 1'b1;
        DivOp    = 2'b01;
        Operand1 = 32'd1000;
        Operand2 = 32'd3;
        tick(1);
        Start = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midop_reset_busy", {31'h0, Busy}, 32'h0);
        check("midop_reset_done", {31'h0, Done}, 32'h0);
        check("midop_reset_result", Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        watch_no_done("reset_no_done", 40);

        // Back-to-back: second Start arrives in the Done cycle of the first.
        do_op("b2b_first", 2'b01, 32'd100, 32'd7, 32'd14, 33, 0);
        do_op("b2b_second", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
